// File: rtl/mem_lsu_if.sv
// Data-memory request bus: req/gnt command phase, rvalid response phase.
interface mem_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_gnt,
        input  dmem_rvalid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_gnt,
        output dmem_rvalid,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues one data-memory access per instruction,
// stalls the pipeline until it completes, and aligns/extends load data.
module mem_lsu #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_in,
    input  logic         mem_rd_en_in,
    input  logic         mem_wr_en_in,
    input  logic [2:0]   funct3_in,
    input  logic [31:0]  alu_result_in,
    input  logic [31:0]  wr_data_in,
    mem_lsu_if.master    dmem,
    output logic [31:0]  mem_rd_data_out,
    output logic         lsu_stall,
    output logic         misaligned_out,
    output logic         timeout_out
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_t;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    logic            we_q;
    logic [31:0]     addr_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [31:0]     rd_data_q;

    logic            access;
    logic            is_byte;
    logic            is_half;
    logic            misaligned;
    logic [1:0]      off;
    logic [3:0]      st_be;
    logic [31:0]     st_wdata;
    logic            latch;
    logic            capture;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_data;

    // Decode the instruction in EX/MEM: size, alignment and store lanes.
    // funct3[1:0] of 10/11 both decode as word, so unsupported codes act as W.
    always_comb begin
        access     = valid_in & (mem_rd_en_in | mem_wr_en_in);
        off        = alu_result_in[1:0];
        is_byte    = (funct3_in[1:0] == 2'b00);
        is_half    = (funct3_in[1:0] == 2'b01);
        misaligned = is_half ? off[0] : (!is_byte && (off != 2'b00));
        st_be      = 4'b1111;
        st_wdata   = wr_data_in;
        if (is_byte) begin
            st_be    = 4'b0001 << off;
            st_wdata = {4{wr_data_in[7:0]}};
        end else if (is_half) begin
            st_be    = 4'b0011 << off;
            st_wdata = {2{wr_data_in[15:0]}};
        end
    end

    // Next-state, stall and request control.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        timeout_d      = 1'b0;
        latch          = 1'b0;
        capture        = 1'b0;
        dmem.dmem_req  = 1'b0;
        lsu_stall      = 1'b0;
        misaligned_out = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    if (misaligned) begin
                        misaligned_out = 1'b1;
                    end else begin
                        lsu_stall = 1'b1;
                        latch     = 1'b1;
                        cnt_d     = '0;
                        state_d   = StReq;
                    end
                end
            end
            StReq: begin
                dmem.dmem_req = 1'b1;
                lsu_stall     = 1'b1;
                cnt_d         = cnt_q + CntW'(1);
                if (dmem.dmem_gnt) begin
                    state_d = we_q ? StDone : StWait;
                end else if (cnt_q == CntLast) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end
            end
            StWait: begin
                lsu_stall = 1'b1;
                cnt_d     = cnt_q + CntW'(1);
                if (dmem.dmem_rvalid) begin
                    capture = 1'b1;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end
            end
            StDone: begin
                // Release the pipeline for one cycle; never start a new access here.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, wait counter and registered timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Request fields are captured on issue and held stable until grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
        end else if (latch) begin
            we_q    <= mem_wr_en_in;
            addr_q  <= {alu_result_in[31:2], 2'b00};
            be_q    <= mem_wr_en_in ? st_be : 4'b1111;
            wdata_q <= st_wdata;
            f3_q    <= funct3_in;
            off_q   <= off;
        end
    end

    // Select and extend the addressed lane of the returned word.
    always_comb begin
        ld_byte = dmem.dmem_rdata[8*off_q +: 8];
        ld_half = dmem.dmem_rdata[16*off_q[1] +: 16];
        unique case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dmem.dmem_rdata;
        endcase
    end

    // Load result register: only a completed load updates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (capture) begin
            rd_data_q <= ld_data;
        end
    end

    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign mem_rd_data_out = rd_data_q;
    assign timeout_out     = timeout_q;

endmodule
